// File: rtl/aes_byte_sequencer.sv
// aes_byte_sequencer: byte-stream command front end that loads key/data into aes_serial_interface and streams results back.
module aes_byte_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] aes_data_in,
  output logic [4:0] aes_addr,
  output logic       aes_wr_en,
  output logic       aes_start,
  output logic       aes_decrypt,
  input  logic [7:0] aes_data_out,
  input  logic       aes_done,
  output logic       seq_busy,
  output logic       err,
  output logic [1:0] err_code
);
  localparam logic [3:0] S_CMD   = 4'd0;
  localparam logic [3:0] S_KEY   = 4'd1;
  localparam logic [3:0] S_DATA  = 4'd2;
  localparam logic [3:0] S_GAP   = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_RADDR = 4'd6;
  localparam logic [3:0] S_RCAP  = 4'd7;
  localparam logic [3:0] S_SEND  = 4'd8;
  localparam logic [3:0] S_REL   = 4'd9;
  logic [3:0]       r_state;
  logic [3:0]       r_idx;
  logic [TMO_W-1:0] r_tmo;
  logic             r_key_loaded;
  logic             w_is_key;
  assign in_ready = rst && (r_state == S_CMD || r_state == S_KEY || r_state == S_DATA);
  assign seq_busy = r_state != S_CMD;
  assign w_is_key = r_state == S_KEY;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_CMD;
      r_idx        <= 4'd0;
      r_tmo        <= '0;
      r_key_loaded <= 1'b0;
      out_data     <= 8'd0;
      out_valid    <= 1'b0;
      aes_data_in  <= 8'd0;
      aes_addr     <= 5'd0;
      aes_wr_en    <= 1'b0;
      aes_start    <= 1'b0;
      aes_decrypt  <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      aes_wr_en <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      case (r_state)
        S_CMD: if (in_valid) begin
          if (|in_data[7:2]) begin
            err      <= 1'b1;
            err_code <= 2'd1;
          end else if (!in_data[1] && !r_key_loaded) begin
            err      <= 1'b1;
            err_code <= 2'd2;
          end else begin
            aes_decrypt <= in_data[0];
            r_idx       <= 4'd0;
            r_state     <= in_data[1] ? S_KEY : S_DATA;
          end
        end
        S_KEY, S_DATA: if (in_valid) begin
          aes_wr_en   <= 1'b1;
          aes_addr    <= {w_is_key, r_idx};
          aes_data_in <= in_data;
          r_idx       <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_key_loaded <= r_key_loaded | w_is_key;
            r_state      <= w_is_key ? S_DATA : S_GAP;
          end
        end
        S_GAP: r_state <= S_START;
        S_START: begin
          aes_start <= 1'b1;
          r_tmo     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (aes_done) begin
          r_idx    <= 4'd0;
          aes_addr <= 5'd0;
          r_state  <= S_RADDR;
        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err         <= 1'b1;
          err_code    <= 2'd3;
          aes_start   <= 1'b0;
          aes_decrypt <= 1'b0;
          r_state     <= S_CMD;
        end else r_tmo <= r_tmo + TMO_W'(1);
        S_RADDR: r_state <= S_RCAP;
        S_RCAP: begin
          out_data  <= aes_data_out;
          out_valid <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: if (out_ready) begin
          out_valid <= 1'b0;
          r_idx     <= r_idx + 4'd1;
          aes_addr  <= {1'b0, r_idx + 4'd1};
          r_state   <= r_idx == 4'd15 ? S_REL : S_RADDR;
        end
        S_REL: begin
          aes_start <= 1'b0;
          if (!aes_done) begin
            aes_decrypt <= 1'b0;
            r_state     <= S_CMD;
          end
        end
        default: r_state <= S_CMD;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_byte_sequencer.sv
// tb_aes_byte_sequencer: scoreboard bench with a behavioural aes_serial_interface stand-in.
module tb_aes_byte_sequencer;
  logic clk = 0, rst = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_ready;
  logic [7:0] out_data;
  logic out_valid, out_ready = 1;
  logic [7:0] aes_data_in, aes_data_out;
  logic [4:0] aes_addr;
  logic aes_wr_en, aes_start, aes_decrypt, aes_done = 0;
  logic seq_busy, err;
  logic [1:0] err_code;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  always #5 clk = ~clk;
  aes_byte_sequencer #(.TIMEOUT_CYCLES(16), .TMO_W(5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .aes_data_in(aes_data_in), .aes_addr(aes_addr), .aes_wr_en(aes_wr_en),
    .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_data_out(aes_data_out),
    .aes_done(aes_done), .seq_busy(seq_busy), .err(err), .err_code(err_code));
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask
  // Interface stand-in: done rises a few cycles after start, drops once start is released.
  logic [127:0] resp = 0;
  logic done_en = 1;
  int dcnt = 0;
  always @(posedge clk)
    if (!aes_start) begin
      dcnt <= 0;
      aes_done <= 0;
    end else if (dcnt == 3) aes_done <= done_en;
    else dcnt <= dcnt + 1;
  assign aes_data_out = resp[127 - 8*aes_addr[3:0] -: 8];
  logic [12:0] exp_wr[$];
  logic [7:0] exp_out[$];
  logic [1:0] exp_err[$];
  logic exp_dec = 0, prev_start = 0, chk_after_tmo = 0;
  logic [12:0] w_pop;
  logic [1:0] e_pop;
  int stall_left = 0, out_idx = 0, cyc = 0, t_start = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst) begin
      if (aes_wr_en) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          w_pop = exp_wr.pop_front();
          chk("wr_addr", aes_addr, w_pop[12:8]);
          chk("wr_data", aes_data_in, w_pop[7:0]);
          chk("wr_decrypt", aes_decrypt, exp_dec);
        end
      end
      if (aes_start && !prev_start) t_start = cyc;
      prev_start = aes_start;
      if (chk_after_tmo) begin
        chk("start_after_tmo", aes_start, 0);
        chk("busy_after_tmo", seq_busy, 0);
        chk_after_tmo = 0;
      end
      if (err) begin
        chk("err_with_valid", out_valid, 0);
        if (exp_err.size() == 0) flag("unexpected_err");
        else begin
          e_pop = exp_err.pop_front();
          chk("err_code", err_code, e_pop);
          if (e_pop == 3) begin
            chk("tmo_cycles", cyc - t_start, 16);
            chk("start_at_tmo", aes_start, 0);
            chk_after_tmo = 1;
          end
        end
      end
      if (out_valid) begin
        out_ready = !(out_idx == 5 && stall_left > 0);
        chk("rd_addr", aes_addr, out_idx);
        chk("start_held", aes_start, 1);
        chk("out_decrypt", aes_decrypt, exp_dec);
        if (exp_out.size() == 0) flag("unexpected_out");
        else chk("out_data", out_data, exp_out[0]);
        if (out_ready) begin
          if (exp_out.size() != 0) void'(exp_out.pop_front());
          out_idx++;
        end else stall_left--;
      end else out_ready = 1;
    end
  end
  task automatic send(input logic [7:0] b);
    int n;
    in_data = b;
    in_valid = 1;
    for (n = 0; n < 5000 && !in_ready; n++) @(negedge clk);
    if (!in_ready) flag("in_ready_timeout");
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_idle();
    repeat (2) @(negedge clk);
    #1;
    for (int n = 0; n < 2000 && seq_busy; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_busy", seq_busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_start", aes_start, 0);
    chk("idle_decrypt", aes_decrypt, 0);
    chk("idle_queues", exp_wr.size() + exp_out.size() + exp_err.size(), 0);
  endtask
  task automatic op(input logic [7:0] cmd, input logic [127:0] key, input logic [127:0] data,
                    input logic [127:0] result, input int stall);
    exp_dec = cmd[0];
    resp = result;
    out_idx = 0;
    stall_left = stall;
    if (cmd[1]) for (int i = 0; i < 16; i++) exp_wr.push_back({5'(16 + i), key[127 - 8*i -: 8]});
    for (int i = 0; i < 16; i++) exp_wr.push_back({5'(i), data[127 - 8*i -: 8]});
    for (int i = 0; i < 16; i++) exp_out.push_back(result[127 - 8*i -: 8]);
    send(cmd);
    if (cmd[1]) for (int i = 0; i < 16; i++) send(key[127 - 8*i -: 8]);
    for (int i = 0; i < 16; i++) send(data[127 - 8*i -: 8]);
    wait_idle();
    chk("outputs_seen", out_idx, 16);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {in_ready, out_valid, out_data, aes_data_in, aes_addr, aes_wr_en, aes_start,
                     aes_decrypt, seq_busy, err, err_code}, 0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    exp_err.push_back(2);
    send(8'h00);
    wait_idle();
    exp_err.push_back(1);
    send(8'h84);
    wait_idle();
    op(8'h02, KEY, PT, CT, 0);
    op(8'h01, 128'h0, CT, PT, 20);
    chk("stall_consumed", stall_left, 0);
    done_en = 0;
    exp_dec = 0;
    exp_err.push_back(3);
    for (int i = 0; i < 16; i++) exp_wr.push_back({5'(i), PT[127 - 8*i -: 8]});
    send(8'h00);
    for (int i = 0; i < 16; i++) send(PT[127 - 8*i -: 8]);
    wait_idle();
    done_en = 1;
    for (int i = 0; i < 7; i++) exp_wr.push_back({5'(16 + i), KEY[127 - 8*i -: 8]});
    send(8'h02);
    for (int i = 0; i < 7; i++) send(KEY[127 - 8*i -: 8]);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    #1;
    chk("midrst_outs", {in_ready, out_valid, out_data, aes_data_in, aes_addr, aes_wr_en, aes_start,
                        aes_decrypt, seq_busy, err, err_code}, 0);
    chk("midrst_writes", exp_wr.size(), 0);
    rst = 1;
    @(negedge clk);
    exp_err.push_back(2);
    send(8'h00);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no completion expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
